// File: rtl/sub_op_uart_responder_if.sv
// Operand/result bus between the UART responder and the subtraction op under test.
// There is no handshake on this bus: op_lhs/op_rhs are held stable by the
// responder, and the op presents op_result combinationally from them. The
// responder samples op_result in the single cycle it spends in EXEC.
interface sub_op_uart_responder_if #(
  parameter int OPERAND_WIDTH = 32
);
  logic [OPERAND_WIDTH-1:0] op_lhs;
  logic [OPERAND_WIDTH-1:0] op_rhs;
  logic [OPERAND_WIDTH-1:0] op_result;

  // Responder side: drives operands, reads result.
  modport master (output op_lhs, output op_rhs, input op_result);
  // Op side: reads operands, drives result.
  modport slave (input op_lhs, input op_rhs, output op_result);
endinterface

// File: rtl/sub_op_uart_responder.sv
// UART responder for on-device testing of a subtraction op. Receives an
// lhs/rhs operand frame (little-endian, 8N1), presents the operands to the op,
// captures its result and sends it back as a little-endian 8N1 frame.
module sub_op_uart_responder #(
  parameter int OPERAND_WIDTH = 32,
  parameter int CLKS_PER_BIT  = 868
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            uart_rx,
  output logic                            uart_tx,
  sub_op_uart_responder_if.master         op,
  output logic                            busy,
  output logic                            err,
  output logic [1:0]                      dbg_state_o,
  output logic [2:0]                      dbg_rx_state_o
);
  localparam int NBYTES = OPERAND_WIDTH / 8;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int KW     = $clog2(2 * NBYTES);
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
  typedef enum logic [1:0] {ST_RECV, ST_EXEC, ST_SEND} state_e;

  // ---------------- RX front end ----------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done;   // good byte, valid in its mid-stop-bit cycle
  logic            rx_ferr;   // framing error, same cycle

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX bit-timing state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: half-bit start check, 8 data samples, stop sample.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // A line that is high again mid-start-bit was a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_done    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        // After a bad stop bit, resynchronise only once the line idles high.
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Top FSM and TX ----------------
  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [OPERAND_WIDTH-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
  logic                     tx_q, tx_d;
  logic [OPERAND_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [CW-1:0]            tx_cnt_q, tx_cnt_d;
  logic [3:0]               tx_bit_q, tx_bit_d;   // 0 start, 1..8 data, 9 stop
  logic [BW-1:0]            tx_byte_q, tx_byte_d;
  logic                     drop;

  // Top state, operand and transmitter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RECV;
      k_q       <= '0;
      lhs_q     <= '0;
      rhs_q     <= '0;
      tx_q      <= 1'b1;
      tx_buf_q  <= '0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      tx_q      <= tx_d;
      tx_buf_q  <= tx_buf_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Frame assembly, one-cycle result capture, then back-to-back byte transmit.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    tx_d      = tx_q;
    tx_buf_d  = tx_buf_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_byte_d = tx_byte_q;
    drop      = 1'b0;
    case (state_q)
      ST_RECV: begin
        if (rx_ferr) begin
          k_d = '0;
        end else if (rx_done) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (k_q == KW'(i))          lhs_d[8*i +: 8] = rx_shift_q;
            if (k_q == KW'(NBYTES + i)) rhs_d[8*i +: 8] = rx_shift_q;
          end
          if (k_q == KW'(2 * NBYTES - 1)) begin
            k_d     = '0;
            state_d = ST_EXEC;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      ST_EXEC: begin
        // Start bit is loaded here so it appears on the line next cycle.
        drop      = rx_done;
        tx_buf_d  = op.op_result;
        tx_d      = 1'b0;
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
        tx_byte_d = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        drop = rx_done;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (tx_byte_q == BW'(NBYTES - 1)) begin
              tx_d    = 1'b1;
              state_d = ST_RECV;
            end else begin
              tx_d      = 1'b0;
              tx_byte_d = tx_byte_q + BW'(1);
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              // Whole result shifts LSB first, which is little-endian byte order.
              tx_d     = tx_buf_q[0];
              tx_buf_d = tx_buf_q >> 1;
            end
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  assign uart_tx        = tx_q;
  assign op.op_lhs      = lhs_q;
  assign op.op_rhs      = rhs_q;
  assign busy           = (state_q != ST_RECV);
  assign err            = rx_ferr | drop;
  assign dbg_state_o    = state_q;
  assign dbg_rx_state_o = rx_state_q;
endmodule

// File: tb/tb_sub_op_uart_responder.sv
// Bench for sub_op_uart_responder with 16-bit operands and 4 clocks per bit.
module tb_sub_op_uart_responder;
  localparam int OW        = 16;
  localparam int CPB       = 4;
  localparam int NB        = OW / 8;
  localparam int FRAME_CYC = 10 * CPB * NB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx, busy, err;
  logic [1:0] dbg_state;
  logic [2:0] dbg_rx_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_op_uart_responder_if #(.OPERAND_WIDTH(OW)) ifc ();
  // The attached op under test: plain modular subtraction.
  assign ifc.op_result = ifc.op_lhs - ifc.op_rhs;

  sub_op_uart_responder #(.OPERAND_WIDTH(OW), .CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rx        (uart_rx),
    .uart_tx        (uart_tx),
    .op             (ifc),
    .busy           (busy),
    .err            (err),
    .dbg_state_o    (dbg_state),
    .dbg_rx_state_o (dbg_rx_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          err_seen = 0;
  logic [7:0]  frame_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  bit          err_exp[int];
  bit          resp_active = 1'b0;
  int          resp_start = 0;
  logic [OW-1:0] resp_val = '0;
  logic [OW-1:0] exp_lhs = '0;
  logic [OW-1:0] exp_rhs = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // busy covers the EXEC cycle plus the whole response.
  function automatic bit in_window(input int c);
    return resp_active && (c >= resp_start - 1) && (c <= resp_start - 1 + FRAME_CYC);
  endfunction

  // Expected serial line level in cycle c, from the 8N1 framing of resp_val.
  function automatic logic exp_tx(input int c);
    int idx, w, by;
    if (!resp_active || c < resp_start || c >= resp_start + FRAME_CYC) return 1'b1;
    idx = (c - resp_start) / CPB;
    by  = idx / 10;
    w   = idx % 10;
    if (w == 0) return 1'b0;
    if (w == 9) return 1'b1;
    return resp_val[8*by + (w - 1)];
  endfunction

  // Byte-level behaviour: what happens to a byte whose stop sample is at t_stop.
  task automatic model_byte(input logic [7:0] b, input bit good, input int t_stop);
    if (in_window(t_stop)) begin
      err_exp[t_stop] = 1'b1;
      return;
    end
    if (!good) begin
      err_exp[t_stop] = 1'b1;
      frame_q.delete();
      return;
    end
    frame_q.push_back(b);
    if (frame_q.size() == 2 * NB) begin
      for (int i = 0; i < NB; i++) begin
        exp_lhs[8*i +: 8] = frame_q[i];
        exp_rhs[8*i +: 8] = frame_q[NB + i];
      end
      resp_val    = exp_lhs - exp_rhs;
      resp_start  = t_stop + 2;
      resp_active = 1'b1;
      frame_q.delete();
      for (int i = 0; i < NB; i++) exp_q.push_back(resp_val[8*i +: 8]);
    end
  endtask

  task automatic model_reset();
    resp_active = 1'b0;
    frame_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks (entered on a falling clock edge) ----------------
  task automatic send_byte(input logic [7:0] b, input bit good);
    int t_stop;
    t_stop = cyc + 10 * CPB;
    model_byte(b, good, t_stop);
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      uart_rx = 1'b0;
      else if (j == 9) uart_rx = good;
      else             uart_rx = b[j-1];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic wait_resp();
    repeat (FRAME_CYC + 6) @(negedge clk);
  endtask

  task automatic chk_resp(input string name, input logic [7:0] lo, input logic [7:0] hi);
    chk({name, "_len"}, 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk({name, "_b0"}, 32'(got_q[0]), 32'(lo));
      chk({name, "_b1"}, 32'(got_q[1]), 32'(hi));
    end
    got_q.delete();
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("tx_in_reset", 32'(uart_tx), 32'd1);
      chk("busy_in_reset", 32'(busy), 32'd0);
      chk("err_in_reset", 32'(err), 32'd0);
    end else begin
      chk("uart_tx", 32'(uart_tx), 32'(exp_tx(cyc)));
      chk("busy", 32'(busy), 32'(in_window(cyc)));
      chk("err", 32'(err), 32'(err_exp.exists(cyc)));
    end
  end

  // ---------------- serial monitor on uart_tx ----------------
  bit         mon_on = 1'b0;
  int         mon_cnt = 0;
  logic       mon_prev = 1'b1;
  logic [7:0] mon_sh = '0;

  always @(negedge clk) begin : mon
    int idx;
    if (!rst) begin
      mon_on   = 1'b0;
      mon_prev = 1'b1;
    end else begin
      if (err) err_seen++;
      if (!mon_on) begin
        if (mon_prev && !uart_tx) begin
          mon_on  = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          idx = mon_cnt / CPB;
          if (idx >= 1 && idx <= 8) begin
            mon_sh = {uart_tx, mon_sh[7:1]};
          end else if (idx == 9) begin
            mon_on = 1'b0;
            got_q.push_back(mon_sh);
            if (exp_q.size() > 0) begin
              chk("resp_byte", 32'(mon_sh), 32'(exp_q.pop_front()));
            end else begin
              n_vec++;
              n_err++;
              $display("FAIL resp_byte: got unexpected byte %0h at cycle %0d", mon_sh, cyc);
            end
          end
        end
      end
      mon_prev = uart_tx;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int e0;
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_op_lhs", 32'(ifc.op_lhs), 32'd0);
    chk("rst_op_rhs", 32'(ifc.op_rhs), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 0x1234 - 0x0034
    send4(8'h34, 8'h12, 8'h34, 8'h00);
    chk("model_a", 32'(resp_val), 32'h1200);
    wait_resp();
    chk_resp("resp_a", 8'h00, 8'h12);
    chk("op_lhs_a", 32'(ifc.op_lhs), 32'h1234);
    chk("op_rhs_a", 32'(ifc.op_rhs), 32'h0034);

    // 0x0000 - 0x0001 wraps
    send4(8'h00, 8'h00, 8'h01, 8'h00);
    chk("model_b", 32'(resp_val), 32'hFFFF);
    wait_resp();
    chk_resp("resp_b", 8'hFF, 8'hFF);
    repeat (20) @(negedge clk);
    chk("op_lhs_b_held", 32'(ifc.op_lhs), 32'h0000);
    chk("op_rhs_b_held", 32'(ifc.op_rhs), 32'h0001);

    // Bad stop bit on the second byte, then a clean frame
    e0 = err_seen;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("ferr_pulses", 32'(err_seen - e0), 32'd1);
    chk("ferr_no_resp", 32'(got_q.size()), 32'd0);
    send4(8'h05, 8'h00, 8'h03, 8'h00);
    wait_resp();
    chk_resp("resp_c", 8'h02, 8'h00);

    // One-cycle low glitch in the middle of a frame
    e0 = err_seen;
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("model_d", 32'(resp_val), 32'h1224);
    wait_resp();
    chk_resp("resp_d", 8'h24, 8'h12);
    chk("glitch_no_err", 32'(err_seen - e0), 32'd0);

    // Extra byte arriving during SEND is dropped
    e0 = err_seen;
    send4(8'h09, 8'h00, 8'h04, 8'h00);
    send_byte(8'hAA, 1'b1);
    repeat (FRAME_CYC) @(negedge clk);
    chk_resp("resp_e", 8'h05, 8'h00);
    chk("drop_pulses", 32'(err_seen - e0), 32'd1);
    send4(8'h00, 8'h01, 8'h01, 8'h00);
    wait_resp();
    chk_resp("resp_f", 8'hFF, 8'h00);

    // Reset during the second response byte
    send4(8'h07, 8'h00, 8'h02, 8'h00);
    repeat (48) @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_tx", 32'(uart_tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_op_lhs", 32'(ifc.op_lhs), 32'd0);
    repeat (3) @(negedge clk);
    chk("trunc_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("trunc_b0", 32'(got_q[0]), 32'h05);
    got_q.delete();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send4(8'h08, 8'h00, 8'h03, 8'h00);
    wait_resp();
    chk_resp("resp_g", 8'h05, 8'h00);
    chk("op_lhs_g", 32'(ifc.op_lhs), 32'h0008);
    chk("op_rhs_g", 32'(ifc.op_rhs), 32'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sub_op_uart_responder.md
# sub_op_uart_responder

UART-facing responder for on-device testing of the subtraction operation. It receives an operand frame from the host over a serial line and drives the operands onto an attached subtraction op. It then captures the result and transmits it back to the host. It sits inside the device-level test top alongside the op under test, standing in for the host-side test driver.

## Interface
- OPERAND_WIDTH, 32, operand/result width in bits; multiple of 8, at least 8; NBYTES = OPERAND_WIDTH/8
- CLKS_PER_BIT, 868, clock cycles per UART bit; at least 4
- clk  input  1  single clock; every flop is on the rising edge
- rst  input  1  asynchronous, active-low reset; asserting it resets all state at once, deasserting it resumes on the next clk edge
- uart_rx  input  1  serial in from host, 8N1, LSB first, idle high; asynchronous to clk
- uart_tx  output  1  serial out to host, 8N1, LSB first, idle high
- op_lhs  output  OPERAND_WIDTH  minuend to the op under test
- op_rhs  output  OPERAND_WIDTH  subtrahend to the op under test
- op_result  input  OPERAND_WIDTH  difference from the op under test (combinational)
- busy  output  1  high in EXEC and SEND
- err  output  1  one-cycle pulse on a framing error or a dropped byte

## Operation
- Request frame: NBYTES lhs bytes, then NBYTES rhs bytes, each little-endian. Response frame: NBYTES result bytes, little-endian.
- RX front end:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts a byte. The line is re-sampled CLKS_PER_BIT/2 cycles later; if it is high, the start is discarded silently.
  - 8 data bits are then sampled every CLKS_PER_BIT cycles, followed by the stop bit.
  - If the stop bit is low: err pulses, the byte is dropped, the frame byte counter clears to 0, and the receiver waits for the line to go idle high before looking for a new start.
- Top FSM states: RECV, EXEC, SEND.
  - RECV: each good byte is written into lhs byte k (k < NBYTES) or rhs byte k-NBYTES; k increments. On the byte that makes k = 2*NBYTES, go to EXEC and clear k.
  - EXEC: lasts one cycle. op_lhs/op_rhs are already stable; op_result is registered into the TX shift buffer. Go to SEND.
  - SEND: transmit NBYTES bytes, each as 1 start bit, 8 data bits and 1 stop bit, back to back with no idle gap. After the last stop bit, go to RECV.
- Any byte completed while in EXEC or SEND is dropped and err pulses. The RX front end keeps running so it stays aligned.
- op_lhs/op_rhs are driven directly from the operand registers. They hold their values until they are overwritten by the next frame.
- Subtraction is modulo 2^OPERAND_WIDTH. The responder returns whatever op_result presents and performs no arithmetic itself.
- There is no inter-byte timeout. A partial frame waits indefinitely, and only a framing error or reset clears it.

## Timing
- Reset values: uart_tx=1, op_lhs=0, op_rhs=0, busy=0, err=0, FSM=RECV, all counters 0, RX idle.
- RX byte completion is the mid-stop-bit sample. If the final rhs byte completes at cycle T:
  - EXEC is at T+1 and busy rises at T+1.
  - The uart_tx start bit begins at T+2.
- Each bit is exactly CLKS_PER_BIT cycles. The response lasts 10*CLKS_PER_BIT*NBYTES cycles.
- busy falls, and the FSM re-enters RECV, on the cycle after the last stop bit ends.
- Reset asserted mid-SEND forces uart_tx high immediately (asynchronous) and aborts the response; the host sees a truncated frame.
- Reset asserted mid-RECV discards the partial frame.
- err is a single-cycle pulse coincident with the stop-bit sample of the offending byte.

## Test plan
- OPERAND_WIDTH=16, CLKS_PER_BIT=4; send 0x34,0x12,0x34,0x00 (0x1234-0x0034) -> response 0x00,0x12; start bit 2 cycles after the last rx stop sample; busy high throughout.
- Send 0x00,0x00,0x01,0x00 (0x0000-0x0001) -> response 0xFF,0xFF (wrap-around); op_lhs=0x0000, op_rhs=0x0001 held afterwards.
- Corrupt the stop bit of the 2nd byte -> err pulses once, no response; then send a full valid frame 0x05,0x00,0x03,0x00 -> response 0x02,0x00.
- Pull uart_rx low for 1 cycle only -> no byte accepted, no err, frame counter unchanged.
- Send one extra byte during SEND -> err pulses, response bytes intact, next frame answered correctly.
- Assert rst during the 2nd response byte -> uart_tx=1 and busy=0 immediately; after release, a fresh frame is answered normally.
